mod_dm_loadunit: RTL and testbench
==================================

# mod_dm_loadunit

Pipelined load-data alignment and extension unit sitting between data memory and the MEM/WB boundary. Takes the raw memory word, access address and load type, selects the addressed byte lanes, sign- or zero-extends to the datapath width, and detects misaligned or illegal loads. Results are registered through 1 or 2 stages with valid, stall and flush control. Generalises the single-width combinational extender to 32/64-bit data with exception reporting.

## Interface
- DATA_W, 32, datapath width; legal values 32 or 64
- ADDR_W, 32, full access address width
- PIPE_STAGES, 1, output register stages; legal values 1 or 2
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a load is presented this cycle
- in_addr  input  ADDR_W  full access address; low log2(DATA_W/8) bits select lanes
- in_data  input  DATA_W  raw memory word, little-endian lanes (byte 0 = bits [7:0])
- in_type  input  4  0 LW, 1 LHU, 2 LH, 3 LBU, 4 LB, 5 LWU, 6 LD, others reserved
- in_rd  input  5  destination register tag, carried unchanged
- stall  input  1  hold all stage registers
- flush  input  1  kill all in-flight entries
- out_valid  output  1  result valid in final stage
- out_data  output  DATA_W  aligned, extended load result
- out_rd  output  5  destination tag of out_data
- out_exc  output  1  misaligned or illegal load in final stage
- out_badaddr  output  ADDR_W  in_addr of the faulting load; 0 otherwise

## Operation
- Lane offset off = in_addr[log2(DATA_W/8)-1:0]; byte = in_data[8*off +: 8]; half = in_data[8*off +: 16]; word = in_data[8*off +: 32].
- LB/LH: sign-extend to DATA_W. LBU/LHU: zero-extend.
- LW: DATA_W=32 passes word; DATA_W=64 sign-extends word. LWU: zero-extends word (DATA_W=64 only).
- LD: passes in_data (DATA_W=64 only).
- Alignment: halfword requires off[0]=0; word requires off[1:0]=0; LD requires off=0. Byte loads never misalign.
- Illegal: type codes 7-15; LWU and LD when DATA_W=32.
- Misaligned or illegal: data=0, exc=1, badaddr=in_addr, rd passed through. Otherwise exc=0, badaddr=0.
- Alignment, extension and exception logic is combinational in front of stage 1. Stage 2, when present, is a plain copy of stage 1.

## Timing
- Reset (rst_n=0, asynchronous): every stage valid, data, rd, exc and badaddr go to 0 immediately. All outputs read 0 until the first captured load. Reset mid-operation discards all in-flight loads.
- Latency: an input accepted at edge N appears on outputs after edge N+PIPE_STAGES-1. With PIPE_STAGES=1, out_* are valid in the cycle after in_valid.
- Capture: when stall=0 and flush=0, each stage loads from its predecessor; stage 1 loads valid=in_valid.
- A stage holding valid=0 still presents data, rd, exc and badaddr as 0. Its payload is cleared on load, not left stale.
- stall=1, flush=0: all stages hold; inputs are ignored and must be re-presented by the producer.
- flush=1: all stage valid bits and payloads clear to 0 on the next edge, regardless of stall. Flush has priority.
- out_exc is only meaningful with out_valid=1, and is 0 whenever out_valid=0.

## Test plan
- DATA_W=32, PIPE_STAGES=1: LB, addr=0x3, data=0xff345678 -> next cycle out_valid=1, out_data=0xffffffff, out_exc=0. Same with LBU -> 0x000000ff.
- DATA_W=32: LH, addr=0x2, data=0x8001_1234 -> 0xffff8001. LHU -> 0x00008001. LH addr=0x1 -> out_exc=1, out_data=0, out_badaddr=0x00000001.
- DATA_W=32: type 6 (LD) -> out_exc=1. LW, addr=0x1000, data=0xdeadbeef -> 0xdeadbeef, exc=0.
- DATA_W=64: LW, addr=0x4, data=0x8000_0000_1234_5678 -> 0xffffffff80000000. LWU -> 0x0000000080000000. LD, addr=0x8 -> data passed through. LD, addr=0xc -> exc=1.
- PIPE_STAGES=2: three back-to-back loads with rd=1,2,3. Assert stall for 2 cycles after the second load, then flush with the third in flight. Required: rd=1 appears 2 cycles after issue, rd=2 is held through the stall, and rd=3 never appears on out_valid.
- Drop rst_n asynchronously between clock edges while out_valid=1. Required: all outputs read 0 immediately, with no valid output until a new load is presented after rst_n returns to 1.

Source files
------------

// File: rtl/mod_dm_loadunit.sv
// Load-data alignment/extension unit: picks the addressed byte lanes of a raw
// memory word, sign/zero-extends them and flags misaligned or illegal loads.
module mod_dm_loadunit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int PIPE_STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_exc,
    output logic [ADDR_W-1:0] out_badaddr
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    localparam logic [3:0] LT_LW  = 4'd0;
    localparam logic [3:0] LT_LHU = 4'd1;
    localparam logic [3:0] LT_LH  = 4'd2;
    localparam logic [3:0] LT_LBU = 4'd3;
    localparam logic [3:0] LT_LB  = 4'd4;
    localparam logic [3:0] LT_LWU = 4'd5;
    localparam logic [3:0] LT_LD  = 4'd6;

    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] shifted;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_w;

    // Shifting the addressed lane down to bit 0 makes every access size a
    // fixed low slice of the same vector.
    assign off     = in_addr[OFF_W-1:0];
    assign shifted = in_data >> {off, 3'b000};
    assign lane_b  = shifted[7:0];
    assign lane_h  = shifted[15:0];
    assign lane_w  = shifted[31:0];

    logic              misaligned;
    logic              illegal;
    logic              exc_next;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] data_next;
    logic [ADDR_W-1:0] badaddr_next;

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        ext_data   = '0;
        case (in_type)
            LT_LW: begin
                misaligned = (off[1:0] != 2'b00);
                ext_data   = DATA_W'($signed(lane_w));
            end
            LT_LHU: begin
                misaligned = off[0];
                ext_data   = DATA_W'(lane_h);
            end
            LT_LH: begin
                misaligned = off[0];
                ext_data   = DATA_W'($signed(lane_h));
            end
            LT_LBU: ext_data = DATA_W'(lane_b);
            LT_LB:  ext_data = DATA_W'($signed(lane_b));
            LT_LWU: begin
                illegal    = (DATA_W == 32);
                misaligned = (off[1:0] != 2'b00);
                ext_data   = DATA_W'(lane_w);
            end
            LT_LD: begin
                illegal    = (DATA_W == 32);
                misaligned = (off != '0);
                ext_data   = shifted;
            end
            default: illegal = 1'b1;
        endcase
        exc_next     = misaligned | illegal;
        data_next    = exc_next ? '0 : ext_data;
        badaddr_next = exc_next ? in_addr : '0;
    end

    logic              valid_reg   [PIPE_STAGES];
    logic [DATA_W-1:0] data_reg    [PIPE_STAGES];
    logic [4:0]        rd_reg      [PIPE_STAGES];
    logic              exc_reg     [PIPE_STAGES];
    logic [ADDR_W-1:0] badaddr_reg [PIPE_STAGES];

    // Flush beats stall; an empty stage always carries an all-zero payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                valid_reg[i]   <= 1'b0;
                data_reg[i]    <= '0;
                rd_reg[i]      <= '0;
                exc_reg[i]     <= 1'b0;
                badaddr_reg[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                valid_reg[i]   <= 1'b0;
                data_reg[i]    <= '0;
                rd_reg[i]      <= '0;
                exc_reg[i]     <= 1'b0;
                badaddr_reg[i] <= '0;
            end
        end else if (!stall) begin
            valid_reg[0]   <= in_valid;
            data_reg[0]    <= in_valid ? data_next : '0;
            rd_reg[0]      <= in_valid ? in_rd : '0;
            exc_reg[0]     <= in_valid & exc_next;
            badaddr_reg[0] <= in_valid ? badaddr_next : '0;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                valid_reg[i]   <= valid_reg[i-1];
                data_reg[i]    <= data_reg[i-1];
                rd_reg[i]      <= rd_reg[i-1];
                exc_reg[i]     <= exc_reg[i-1];
                badaddr_reg[i] <= badaddr_reg[i-1];
            end
        end
    end

    assign out_valid   = valid_reg[PIPE_STAGES-1];
    assign out_data    = data_reg[PIPE_STAGES-1];
    assign out_rd      = rd_reg[PIPE_STAGES-1];
    assign out_exc     = exc_reg[PIPE_STAGES-1];
    assign out_badaddr = badaddr_reg[PIPE_STAGES-1];

endmodule

// File: tb/tb_mod_dm_loadunit.sv
// Scoreboard bench: a 32-bit single-stage unit and a 64-bit two-stage unit,
// directed loads pushed as expectations and checked by per-unit monitors.
module tb_mod_dm_loadunit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 32-bit, 1 stage
    logic        a_valid, a_stall, a_flush;
    logic [31:0] a_addr, a_data;
    logic [3:0]  a_type;
    logic [4:0]  a_rd;
    logic        a_ovalid, a_oexc;
    logic [31:0] a_odata, a_obad;
    logic [4:0]  a_ord;

    // 64-bit, 2 stages
    logic        b_valid, b_stall, b_flush;
    logic [31:0] b_addr;
    logic [63:0] b_data;
    logic [3:0]  b_type;
    logic [4:0]  b_rd;
    logic        b_ovalid, b_oexc;
    logic [63:0] b_odata;
    logic [31:0] b_obad;
    logic [4:0]  b_ord;

    mod_dm_loadunit #(.DATA_W(32), .ADDR_W(32), .PIPE_STAGES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_addr(a_addr),
        .in_data(a_data), .in_type(a_type), .in_rd(a_rd), .stall(a_stall),
        .flush(a_flush), .out_valid(a_ovalid), .out_data(a_odata),
        .out_rd(a_ord), .out_exc(a_oexc), .out_badaddr(a_obad)
    );

    mod_dm_loadunit #(.DATA_W(64), .ADDR_W(32), .PIPE_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_addr(b_addr),
        .in_data(b_data), .in_type(b_type), .in_rd(b_rd), .stall(b_stall),
        .flush(b_flush), .out_valid(b_ovalid), .out_data(b_odata),
        .out_rd(b_ord), .out_exc(b_oexc), .out_badaddr(b_obad)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        exc;
        logic [31:0] bad;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor A: compare head of queue while valid; retire it when the
    // output is about to move on (no stall, or flushed).
    always @(negedge clk) begin
        exp_t e;
        if (a_ovalid) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected: rd=%0d valid with no load outstanding", a_ord);
            end else begin
                e = qa[0];
                check("a_data", {32'b0, a_odata}, e.data);
                check("a_rd", {59'b0, a_ord}, {59'b0, e.rd});
                check("a_exc", {63'b0, a_oexc}, {63'b0, e.exc});
                check("a_bad", {32'b0, a_obad}, {32'b0, e.bad});
                if (!a_stall || a_flush) begin
                    $display("[TB] A rd=%0d data=0x%08h exc=%0d bad=0x%0h", a_ord, a_odata, a_oexc, a_obad);
                    void'(qa.pop_front());
                end
            end
        end else begin
            check("a_idle_data", {32'b0, a_odata}, 64'd0);
            check("a_idle_meta", {26'b0, a_ord, a_oexc, a_obad}, 64'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_ovalid) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: rd=%0d valid with no load outstanding", b_ord);
            end else begin
                e = qb[0];
                check("b_data", b_odata, e.data);
                check("b_rd", {59'b0, b_ord}, {59'b0, e.rd});
                check("b_exc", {63'b0, b_oexc}, {63'b0, e.exc});
                check("b_bad", {32'b0, b_obad}, {32'b0, e.bad});
                if (!b_stall || b_flush) begin
                    $display("[TB] B rd=%0d data=0x%016h exc=%0d bad=0x%0h", b_ord, b_odata, b_oexc, b_obad);
                    void'(qb.pop_front());
                end
            end
        end else begin
            check("b_idle_data", b_odata, 64'd0);
            check("b_idle_meta", {26'b0, b_ord, b_oexc, b_obad}, 64'd0);
        end
    end

    task automatic issue_a(input logic [3:0] t, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input logic [31:0] exp_d, input logic exp_exc);
        @(posedge clk);
        #1;
        a_valid = 1'b1; a_type = t; a_addr = addr; a_data = data; a_rd = rd;
        qa.push_back('{data: {32'b0, exp_d}, rd: rd, exc: exp_exc, bad: (exp_exc ? addr : 32'd0)});
    endtask

    task automatic idle_a();
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_type = 4'd0; a_addr = '0; a_data = '0; a_rd = '0;
    endtask

    task automatic issue_b(input logic [3:0] t, input logic [31:0] addr, input logic [63:0] data,
                           input logic [4:0] rd, input logic [63:0] exp_d, input logic exp_exc);
        @(posedge clk);
        #1;
        b_valid = 1'b1; b_type = t; b_addr = addr; b_data = data; b_rd = rd;
        qb.push_back('{data: exp_d, rd: rd, exc: exp_exc, bad: (exp_exc ? addr : 32'd0)});
    endtask

    task automatic idle_b();
        @(posedge clk);
        #1;
        b_valid = 1'b0; b_type = 4'd0; b_addr = '0; b_data = '0; b_rd = '0;
    endtask

    initial begin
        rst_n = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0; a_type = 0; a_rd = 0; a_stall = 0; a_flush = 0;
        b_valid = 0; b_addr = 0; b_data = 0; b_type = 0; b_rd = 0; b_stall = 0; b_flush = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // 32-bit unit: extension, alignment and illegal codes
        issue_a(4'd4, 32'h3,    32'hff345678, 5'd1,  32'hffffffff, 1'b0);
        issue_a(4'd3, 32'h3,    32'hff345678, 5'd2,  32'h000000ff, 1'b0);
        issue_a(4'd2, 32'h2,    32'h80011234, 5'd3,  32'hffff8001, 1'b0);
        issue_a(4'd1, 32'h2,    32'h80011234, 5'd4,  32'h00008001, 1'b0);
        issue_a(4'd2, 32'h1,    32'h80011234, 5'd5,  32'h0,        1'b1);
        idle_a();
        issue_a(4'd6, 32'h10,   32'h12345678, 5'd6,  32'h0,        1'b1);
        issue_a(4'd0, 32'h1000, 32'hdeadbeef, 5'd7,  32'hdeadbeef, 1'b0);
        issue_a(4'd5, 32'h20,   32'hdeadbeef, 5'd8,  32'h0,        1'b1);
        issue_a(4'd9, 32'h44,   32'hdeadbeef, 5'd9,  32'h0,        1'b1);
        issue_a(4'd0, 32'h2,    32'hdeadbeef, 5'd10, 32'h0,        1'b1);
        issue_a(4'd4, 32'h1,    32'h00007f00, 5'd11, 32'h0000007f, 1'b0);
        issue_a(4'd3, 32'h2,    32'h00a50000, 5'd12, 32'h000000a5, 1'b0);
        issue_a(4'd1, 32'h0,    32'h1234cdef, 5'd13, 32'h0000cdef, 1'b0);
        issue_a(4'd2, 32'h0,    32'h1234cdef, 5'd14, 32'hffffcdef, 1'b0);
        idle_a();

        // 64-bit unit
        issue_b(4'd0,  32'h4,  64'h8000000012345678, 5'd1,  64'hffffffff80000000, 1'b0);
        issue_b(4'd5,  32'h4,  64'h8000000012345678, 5'd2,  64'h0000000080000000, 1'b0);
        issue_b(4'd6,  32'h8,  64'h0123456789abcdef, 5'd3,  64'h0123456789abcdef, 1'b0);
        issue_b(4'd6,  32'hc,  64'h0123456789abcdef, 5'd4,  64'h0,                1'b1);
        issue_b(4'd2,  32'h6,  64'hbeef000000000000, 5'd5,  64'hffffffffffffbeef, 1'b0);
        issue_b(4'd4,  32'h7,  64'h8000000000000000, 5'd6,  64'hffffffffffffff80, 1'b0);
        issue_b(4'd0,  32'h2,  64'h0123456789abcdef, 5'd7,  64'h0,                1'b1);
        issue_b(4'd1,  32'h5,  64'h0123456789abcdef, 5'd8,  64'h0,                1'b1);
        issue_b(4'd3,  32'h5,  64'h0000cd0000000000, 5'd9,  64'h00000000000000cd, 1'b0);
        issue_b(4'd0,  32'h28, 64'h000000007fffffff, 5'd10, 64'h000000007fffffff, 1'b0);
        issue_b(4'd12, 32'h0,  64'h0123456789abcdef, 5'd11, 64'h0,                1'b1);
        idle_b();
        repeat (4) @(posedge clk);

        // Two-stage latency, stall hold, then flush (with stall) kills rd=3
        issue_b(4'd6, 32'h0, 64'h1111, 5'd1, 64'h1111, 1'b0);
        @(posedge clk);
        #1;
        check("b_lat_not_yet", {63'b0, b_ovalid}, 64'd0);
        b_type = 4'd6; b_addr = '0; b_data = 64'h2222; b_rd = 5'd2;
        qb.push_back('{data: 64'h2222, rd: 5'd2, exc: 1'b0, bad: 32'd0});
        @(posedge clk);
        #1;
        check("b_lat_valid", {63'b0, b_ovalid}, 64'd1);
        check("b_lat_rd", {59'b0, b_ord}, 64'd1);
        b_data = 64'h3333; b_rd = 5'd3;
        @(posedge clk);
        #1;
        b_valid = 1'b0; b_stall = 1'b1;
        @(posedge clk);
        #1;
        check("b_stall_rd", {59'b0, b_ord}, 64'd2);
        @(posedge clk);
        #1;
        check("b_stall_valid", {63'b0, b_ovalid}, 64'd1);
        b_flush = 1'b1;
        @(posedge clk);
        #1;
        check("b_flush_valid", {63'b0, b_ovalid}, 64'd0);
        b_flush = 1'b0; b_stall = 1'b0;
        repeat (4) @(posedge clk);

        // Asynchronous reset between edges while the 32-bit unit holds a result
        issue_a(4'd0, 32'h0, 32'h0badf00d, 5'd20, 32'h0badf00d, 1'b0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        check("a_pre_reset_valid", {63'b0, a_ovalid}, 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("a_rst_valid", {63'b0, a_ovalid}, 64'd0);
        check("a_rst_data", {32'b0, a_odata}, 64'd0);
        check("a_rst_meta", {26'b0, a_ord, a_oexc, a_obad}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        issue_a(4'd4, 32'h0, 32'h00000080, 5'd21, 32'hffffff80, 1'b0);
        idle_a();

        repeat (6) @(posedge clk);
        check("qa_drained", 64'(qa.size()), 64'd0);
        check("qb_drained", 64'(qb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
